pipe_reg_elastic: RTL and testbench

Parametrised elastic pipeline register that replaces the fixed always-load stage registers between pipeline stages (e.g. MEM→WB). It carries an opaque `DATA_W`-bit payload with a valid/ready handshake, a synchronous flush that inserts a bubble, and an optional 2-entry skid buffer. With the skid buffer enabled, `in_ready` comes from a flop, so the stage breaks the combinational ready path and still sustains one transfer per cycle.

---
 rtl/pipe_reg_elastic.sv | 108 ++++++++++
 tb/tb_pipe_reg_elastic.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register with valid/ready handshake, synchronous flush
// and an optional 2-entry skid buffer that registers in_ready.
`default_nettype none

module pipe_reg_elastic #(
  parameter int DATA_W = 101,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic              skid_load;

  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready & ~flush;
  assign skid_load = (state_q == ONE) & in_fire & ~out_fire;

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_q;

      // in_ready is a pure function of the state flop, so no input reaches it.
      assign in_ready  = (state_q != FULL);
      assign skid_data = skid_q;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          skid_q <= '0;
        end else if (skid_load) begin
          skid_q <= in_data;
        end
      end
    end else begin : g_no_skid
      assign in_ready  = ~out_valid | out_ready;
      assign skid_data = '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_data;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
// Directed self-checking bench: one skid-mode and one plain-mode instance.
`default_nettype none

module tb_pipe_reg_elastic;

  localparam int DATA_W = 101;

  logic clk = 1'b0;
  logic reset;

  logic              flush1, in_valid1, out_ready1;
  logic [DATA_W-1:0] in_data1, out_data1;
  logic              in_ready1, out_valid1;
  logic [1:0]        occ1;

  logic              flush0, in_valid0, out_ready0;
  logic [DATA_W-1:0] in_data0, out_data0;
  logic              in_ready0, out_valid0;
  logic [1:0]        occ0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_reg_elastic #(.DATA_W(DATA_W), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
    .occupancy(occ1)
  );

  pipe_reg_elastic #(.DATA_W(DATA_W), .SKID(1'b0)) u_plain (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
    .occupancy(occ0)
  );

  // Advance past the next rising edge, then let combinational paths settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status vectors below are {out_valid, occupancy, in_ready}.
  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({out_valid1, occ1, in_ready1, out_data1} !== {1'b0, 2'd0, 1'b1, {DATA_W{1'b0}}}) begin
        n_fail++;
        $display("FAIL reset_skid cyc%0d: got v=%b occ=%0d rdy=%b data=%h, need v=0 occ=0 rdy=1 data=0",
                 i, out_valid1, occ1, in_ready1, out_data1);
      end
      n_checks++;
      if ({out_valid0, occ0, in_ready0, out_data0} !== {1'b0, 2'd0, 1'b1, {DATA_W{1'b0}}}) begin
        n_fail++;
        $display("FAIL reset_plain cyc%0d: got v=%b occ=%0d rdy=%b data=%h, need v=0 occ=0 rdy=1 data=0",
                 i, out_valid0, occ0, in_ready0, out_data0);
      end
      step();
    end
  endtask

  task automatic test_stream();
    out_ready1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid1 = 1'b1;
      in_data1  = DATA_W'(i);
      #1;
      n_checks++;
      if (in_ready1 !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready beat%0d: got %b need 1", i, in_ready1);
      end
      step();
      n_checks++;
      if ({out_valid1, occ1, out_data1} !== {1'b1, 2'd1, DATA_W'(i)}) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got v=%b occ=%0d data=%h, need v=1 occ=1 data=%h",
                 i, out_valid1, occ1, out_data1, i);
      end
    end
    in_valid1 = 1'b0;
    step();
    n_checks++;
    if ({out_valid1, occ1} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b occ=%0d need v=0 occ=0", out_valid1, occ1);
    end
  endtask

  task automatic test_backpressure();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = DATA_W'('hA);
    step();
    in_data1 = DATA_W'('hB);
    #1;
    n_checks++;
    if ({out_valid1, occ1, in_ready1} !== {1'b1, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_one: got v=%b occ=%0d rdy=%b need v=1 occ=1 rdy=1", out_valid1, occ1, in_ready1);
    end
    step();
    in_data1 = DATA_W'('hC);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({out_valid1, occ1, in_ready1, out_data1} !== {1'b1, 2'd2, 1'b0, DATA_W'('hA)}) begin
        n_fail++;
        $display("FAIL bp_full cyc%0d: got v=%b occ=%0d rdy=%b data=%h need v=1 occ=2 rdy=0 data=a",
                 i, out_valid1, occ1, in_ready1, out_data1);
      end
      step();
    end
    out_ready1 = 1'b1;
    step();
    n_checks++;
    if ({out_valid1, occ1, in_ready1, out_data1} !== {1'b1, 2'd1, 1'b1, DATA_W'('hB)}) begin
      n_fail++;
      $display("FAIL bp_release_b: got v=%b occ=%0d rdy=%b data=%h need v=1 occ=1 rdy=1 data=b",
               out_valid1, occ1, in_ready1, out_data1);
    end
    step();
    in_valid1 = 1'b0;
    n_checks++;
    if ({out_valid1, occ1, out_data1} !== {1'b1, 2'd1, DATA_W'('hC)}) begin
      n_fail++;
      $display("FAIL bp_release_c: got v=%b occ=%0d data=%h need v=1 occ=1 data=c",
               out_valid1, occ1, out_data1);
    end
    step();
    n_checks++;
    if ({out_valid1, occ1} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b occ=%0d need v=0 occ=0", out_valid1, occ1);
    end
  endtask

  task automatic test_flush_full();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = DATA_W'('hA);
    step();
    in_data1 = DATA_W'('hB);
    step();
    n_checks++;
    if (occ1 !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_setup: got occ=%0d need 2", occ1);
    end
    flush1   = 1'b1;
    in_data1 = DATA_W'('hC);
    step();
    flush1    = 1'b0;
    in_valid1 = 1'b0;
    n_checks++;
    if ({out_valid1, occ1, in_ready1, out_data1} !== {1'b0, 2'd0, 1'b1, {DATA_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL flush_after: got v=%b occ=%0d rdy=%b data=%h need v=0 occ=0 rdy=1 data=0",
               out_valid1, occ1, in_ready1, out_data1);
    end
    out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_leak cyc%0d: got v=%b data=%h need v=0", i, out_valid1, out_data1);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = DATA_W'('h55);
    step();
    n_checks++;
    if ({out_valid1, out_data1} !== {1'b1, DATA_W'('h55)}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got v=%b data=%h need v=1 data=55", out_valid1, out_data1);
    end
    reset = 1'b1;
    step();
    reset     = 1'b0;
    in_valid1 = 1'b0;
    n_checks++;
    if ({out_valid1, occ1, in_ready1, out_data1} !== {1'b0, 2'd0, 1'b1, {DATA_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL rstmid_after: got v=%b occ=%0d rdy=%b data=%h need v=0 occ=0 rdy=1 data=0",
               out_valid1, occ1, in_ready1, out_data1);
    end
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    in_data1   = DATA_W'('h66);
    step();
    in_valid1 = 1'b0;
    n_checks++;
    if ({out_valid1, occ1, out_data1} !== {1'b1, 2'd1, DATA_W'('h66)}) begin
      n_fail++;
      $display("FAIL rstmid_66: got v=%b occ=%0d data=%h need v=1 occ=1 data=66", out_valid1, occ1, out_data1);
    end
    step();
    n_checks++;
    if (out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_alone: got v=%b need 0", out_valid1);
    end
  endtask

  task automatic test_reset_and_flush();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = DATA_W'('h3C);
    step();
    reset  = 1'b1;
    flush1 = 1'b1;
    step();
    reset     = 1'b0;
    flush1    = 1'b0;
    in_valid1 = 1'b0;
    n_checks++;
    if ({out_valid1, occ1, in_ready1, out_data1} !== {1'b0, 2'd0, 1'b1, {DATA_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL rst_flush: got v=%b occ=%0d rdy=%b data=%h need v=0 occ=0 rdy=1 data=0",
               out_valid1, occ1, in_ready1, out_data1);
    end
  endtask

  task automatic test_plain_backpressure();
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_data0   = DATA_W'('h1);
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL plain_empty_ready: got %b need 1", in_ready0);
    end
    step();
    in_data0 = DATA_W'('h2);
    #1;
    n_checks++;
    if ({out_valid0, occ0, in_ready0, out_data0} !== {1'b1, 2'd1, 1'b0, DATA_W'('h1)}) begin
      n_fail++;
      $display("FAIL plain_stall: got v=%b occ=%0d rdy=%b data=%h need v=1 occ=1 rdy=0 data=1",
               out_valid0, occ0, in_ready0, out_data0);
    end
    out_ready0 = 1'b1;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL plain_comb_ready: got %b need 1", in_ready0);
    end
    step();
    in_valid0 = 1'b0;
    n_checks++;
    if ({out_valid0, occ0, out_data0} !== {1'b1, 2'd1, DATA_W'('h2)}) begin
      n_fail++;
      $display("FAIL plain_next: got v=%b occ=%0d data=%h need v=1 occ=1 data=2", out_valid0, occ0, out_data0);
    end
    step();
    n_checks++;
    if ({out_valid0, occ0} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL plain_drain: got v=%b occ=%0d need v=0 occ=0", out_valid0, occ0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    flush1     = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b0;
    flush0     = 1'b0;
    in_valid0  = 1'b0;
    in_data0   = '0;
    out_ready0 = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_reset_mid();
    test_reset_and_flush();
    test_plain_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
